// File: rtl/execute_stage_if.sv
// Bus between the decode/execute buffer, the execute stage and the execute/memory register.
// The stage sits on the slave side. The driver of the E fields and the consumer of the M fields sits on the master side.
interface execute_stage_if #(
    parameter int DBITS   = 32,
    parameter int REGBITS = 4,
    parameter int OPBITS  = 4
);
    logic [DBITS-1:0]   incPC_E;
    logic [DBITS-1:0]   src1Data_E;
    logic [DBITS-1:0]   src2Data_E;
    logic [DBITS-1:0]   signExtImm_E;
    logic [REGBITS-1:0] destIndex_E;
    logic [OPBITS-1:0]  opCode_E;
    logic [4:0]         aluOp_E;
    logic [1:0]         src2Mux_E;
    logic [1:0]         regFileMux_E;
    logic               memWrtEn_E;
    logic               regWrtEn_E;
    logic               noop_E;
    logic [1:0]         pc_sel_E;

    logic               stall_E;
    logic               pcRedirect_E;
    logic [DBITS-1:0]   pcTarget_E;

    logic [DBITS-1:0]   aluResult_M;
    logic [DBITS-1:0]   src2Data_M;
    logic [DBITS-1:0]   incPC_M;
    logic [REGBITS-1:0] destIndex_M;
    logic [OPBITS-1:0]  opCode_M;
    logic [1:0]         regFileMux_M;
    logic               memWrtEn_M;
    logic               regWrtEn_M;
    logic               noop_M;

    modport master (
        output incPC_E, src1Data_E, src2Data_E, signExtImm_E, destIndex_E, opCode_E,
               aluOp_E, src2Mux_E, regFileMux_E, memWrtEn_E, regWrtEn_E, noop_E, pc_sel_E,
        input  stall_E, pcRedirect_E, pcTarget_E,
               aluResult_M, src2Data_M, incPC_M, destIndex_M, opCode_M, regFileMux_M,
               memWrtEn_M, regWrtEn_M, noop_M
    );

    modport slave (
        input  incPC_E, src1Data_E, src2Data_E, signExtImm_E, destIndex_E, opCode_E,
               aluOp_E, src2Mux_E, regFileMux_E, memWrtEn_E, regWrtEn_E, noop_E, pc_sel_E,
        output stall_E, pcRedirect_E, pcTarget_E,
               aluResult_M, src2Data_M, incPC_M, destIndex_M, opCode_M, regFileMux_M,
               memWrtEn_M, regWrtEn_M, noop_M
    );
endinterface

// File: rtl/execute_stage.sv
// Execute stage: ALU, multi-cycle shift-add multiply that stalls upstream,
// branch/jump resolution, and the execute/memory pipeline register.
module execute_stage #(
    parameter int DBITS   = 32,
    parameter int REGBITS = 4,
    parameter int OPBITS  = 4
) (
    input logic             clk,
    input logic             reset,
    execute_stage_if.slave  bus
);
    localparam logic [4:0] ALU_MUL = 5'h18;
    localparam int         CNTW    = $clog2(DBITS);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state, state_nxt;
    logic [CNTW-1:0]    cnt;
    logic [DBITS-1:0]   acc, mcand, mplier;
    logic [DBITS-1:0]   opb, alu_res, wb_res;
    logic               mul_req, stall_int, bubble;

    function automatic logic [DBITS-1:0] alu_f(input logic [4:0] op,
                                               input logic [DBITS-1:0] a,
                                               input logic [DBITS-1:0] b);
        logic signed [DBITS-1:0] a_s;
        logic signed [DBITS-1:0] b_s;
        logic [DBITS-1:0]        r;
        a_s = a;
        b_s = b;
        case (op)
            5'h00:   r = a + b;
            5'h01:   r = a - b;
            5'h02:   r = a & b;
            5'h03:   r = a | b;
            5'h04:   r = a ^ b;
            5'h05:   r = ~(a & b);
            5'h06:   r = ~(a | b);
            5'h07:   r = ~(a ^ b);
            5'h08:   r = {{(DBITS-1){1'b0}}, (a == b)};
            5'h09:   r = {{(DBITS-1){1'b0}}, (a_s < b_s)};
            5'h0A:   r = {{(DBITS-1){1'b0}}, (a_s <= b_s)};
            5'h0B:   r = {{(DBITS-1){1'b0}}, (a != b)};
            default: r = '0;
        endcase
        return r;
    endfunction

    // ---- E stage: operand select, ALU, multiply request ----
    assign opb     = (bus.src2Mux_E == 2'b01) ? bus.signExtImm_E : bus.src2Data_E;
    assign alu_res = alu_f(bus.aluOp_E, bus.src1Data_E, opb);
    assign mul_req = !bus.noop_E && (bus.aluOp_E == ALU_MUL);

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // FSM next-state: start on a MUL, count DBITS steps, one DONE cycle, never re-arm from DONE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (mul_req) state_nxt = BUSY;
            BUSY:    if (cnt == CNTW'(DBITS-1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: upstream stall and whether the M register takes a bubble
    always_comb begin
        stall_int = 1'b0;
        bubble    = 1'b1;
        case (state)
            IDLE: begin
                stall_int = mul_req;
                bubble    = bus.noop_E || mul_req;
            end
            BUSY: begin
                stall_int = 1'b1;
                bubble    = 1'b1;
            end
            DONE: begin
                stall_int = 1'b0;
                bubble    = bus.noop_E;
            end
            default: begin
                stall_int = 1'b0;
                bubble    = 1'b1;
            end
        endcase
    end

    // Gating with reset lets stall fall immediately even while a MUL sits on the inputs.
    assign bus.stall_E = stall_int && reset;

    // Branch/jump resolution: only for a live, non-MUL instruction while the multiplier is idle
    always_comb begin
        bus.pcRedirect_E = 1'b0;
        bus.pcTarget_E   = '0;
        if (!bus.noop_E && (state == IDLE) && !mul_req) begin
            case (bus.pc_sel_E)
                2'b01: begin
                    if (alu_res[0]) begin
                        bus.pcRedirect_E = 1'b1;
                        bus.pcTarget_E   = bus.incPC_E + (bus.signExtImm_E << 2);
                    end
                end
                2'b10: begin
                    bus.pcRedirect_E = 1'b1;
                    bus.pcTarget_E   = bus.src1Data_E + (bus.signExtImm_E << 2);
                end
                default: begin
                    bus.pcRedirect_E = 1'b0;
                    bus.pcTarget_E   = '0;
                end
            endcase
        end
    end

    // The product replaces the ALU result in DONE; a jump-and-link writes back its return address.
    assign wb_res = (state == DONE)                           ? acc          :
                    (bus.pc_sel_E == 2'b10 && !bus.noop_E)    ? bus.incPC_E  : alu_res;

    // Shift-add multiplier: one partial product per BUSY cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (state == IDLE && mul_req) begin
            cnt    <= '0;
            acc    <= '0;
            mcand  <= bus.src1Data_E;
            mplier <= opb;
        end else if (state == BUSY) begin
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CNTW'(1);
        end
    end

    // ---- E/M boundary: execute/memory pipeline register ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.aluResult_M  <= '0;
            bus.src2Data_M   <= '0;
            bus.incPC_M      <= '0;
            bus.destIndex_M  <= '0;
            bus.opCode_M     <= '0;
            bus.regFileMux_M <= '0;
            bus.memWrtEn_M   <= 1'b0;
            bus.regWrtEn_M   <= 1'b0;
            bus.noop_M       <= 1'b1;
        end else begin
            bus.aluResult_M  <= wb_res;
            bus.src2Data_M   <= bus.src2Data_E;
            bus.incPC_M      <= bus.incPC_E;
            bus.destIndex_M  <= bus.destIndex_E;
            bus.opCode_M     <= bus.opCode_E;
            bus.regFileMux_M <= bus.regFileMux_E;
            bus.memWrtEn_M   <= bubble ? 1'b0 : bus.memWrtEn_E;
            bus.regWrtEn_M   <= bubble ? 1'b0 : bus.regWrtEn_E;
            bus.noop_M       <= bubble ? 1'b1 : bus.noop_E;
        end
    end
endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: ALU ops, multi-cycle multiply, branches, reset abort.
module tb_execute_stage;
    logic clk;
    logic reset;
    int   pass_cnt;
    int   total_cnt;

    execute_stage_if #(.DBITS(32), .REGBITS(4), .OPBITS(4)) bus ();

    execute_stage #(.DBITS(32), .REGBITS(4), .OPBITS(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [4:0]  tv_op  [12] = '{5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06,
                                 5'h07, 5'h08, 5'h09, 5'h0A, 5'h0B, 5'h1F};
    logic [31:0] tv_a   [12] = '{32'd5, 32'h0000F0F0, 32'h0000F000, 32'h0000FF00,
                                 32'hFFFFFFFF, 32'h0, 32'hAAAA5555, 32'd3,
                                 32'hFFFFFFFF, 32'd1, 32'd4, 32'd9};
    logic [31:0] tv_b   [12] = '{32'd7, 32'h00000FF0, 32'h0000000F, 32'h00000FF0,
                                 32'h0000FFFF, 32'h0, 32'hAAAA5555, 32'd3,
                                 32'd1, 32'hFFFFFFFF, 32'd3, 32'd9};
    logic [31:0] tv_exp [12] = '{32'hFFFFFFFE, 32'h000000F0, 32'h0000F00F, 32'h0000F0F0,
                                 32'hFFFF0000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,
                                 32'd1, 32'd0, 32'd1, 32'd0};

    task automatic set_e(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic [31:0] pc,
                         input logic [1:0] s2m, input logic [1:0] psel, input logic noop);
        bus.aluOp_E      = op;
        bus.src1Data_E   = a;
        bus.src2Data_E   = b;
        bus.signExtImm_E = imm;
        bus.incPC_E      = pc;
        bus.src2Mux_E    = s2m;
        bus.pc_sel_E     = psel;
        bus.noop_E       = noop;
        bus.regWrtEn_E   = 1'b1;
        bus.memWrtEn_E   = 1'b0;
        bus.destIndex_E  = 4'd3;
        bus.opCode_E     = 4'd1;
        bus.regFileMux_E = 2'd0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        set_e(5'h00, 32'd0, 32'd0, 32'd0, 32'd0, 2'b00, 2'b00, 1'b1);
        @(posedge clk); @(posedge clk); #1;
        total_cnt++;
        if (bus.noop_M !== 1'b1) $display("FAIL reset_noop_M got %0b want 1", bus.noop_M);
        else pass_cnt++;
        total_cnt++;
        if (bus.aluResult_M !== 32'h0) $display("FAIL reset_aluResult_M got %h want 0", bus.aluResult_M);
        else pass_cnt++;
        total_cnt++;
        if (bus.regWrtEn_M !== 1'b0 || bus.stall_E !== 1'b0)
            $display("FAIL reset_ctrl got regWrt=%0b stall=%0b want 0/0", bus.regWrtEn_M, bus.stall_E);
        else pass_cnt++;
        #2 reset = 1'b1;
    endtask

    task automatic test_add();
        @(posedge clk); #1;
        set_e(5'h00, 32'd5, 32'd99, 32'd7, 32'h10, 2'b01, 2'b00, 1'b0);
        #1;
        total_cnt++;
        if (bus.stall_E !== 1'b0) $display("FAIL add_stall got %0b want 0", bus.stall_E);
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if (bus.aluResult_M !== 32'd12 || bus.regWrtEn_M !== 1'b1 || bus.noop_M !== 1'b0)
            $display("FAIL add_result got res=%0d regWrt=%0b noop=%0b want 12/1/0",
                     bus.aluResult_M, bus.regWrtEn_M, bus.noop_M);
        else pass_cnt++;
    endtask

    task automatic test_alu_ops();
        for (int i = 0; i < 12; i++) begin
            set_e(tv_op[i], tv_a[i], tv_b[i], 32'h0, 32'h0, 2'b00, 2'b00, 1'b0);
            @(posedge clk); #1;
            total_cnt++;
            if (bus.aluResult_M !== tv_exp[i])
                $display("FAIL alu_op_%h got %h want %h", tv_op[i], bus.aluResult_M, tv_exp[i]);
            else pass_cnt++;
        end
    endtask

    // Start a MUL, count stall cycles, then check the single product cycle.
    task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic [31:0] prod,
                           input logic follow_add);
        int n;
        logic bubble_ok;
        n = 0;
        bubble_ok = 1'b1;
        set_e(5'h18, a, b, 32'h0, 32'h0, 2'b00, 2'b00, 1'b0);
        #1;
        while (bus.stall_E === 1'b1 && n < 100) begin
            n++;
            @(posedge clk); #1;
            if (bus.stall_E === 1'b1 && (bus.noop_M !== 1'b1 || bus.regWrtEn_M !== 1'b0))
                bubble_ok = 1'b0;
        end
        total_cnt++;
        if (n != 33) $display("FAIL mul_stall_len got %0d want 33", n);
        else pass_cnt++;
        total_cnt++;
        if (!bubble_ok) $display("FAIL mul_bubbles got non-bubble want bubble");
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if (bus.aluResult_M !== prod || bus.noop_M !== 1'b0 || bus.regWrtEn_M !== 1'b1)
            $display("FAIL mul_product got %h noop=%0b want %h noop=0", bus.aluResult_M, bus.noop_M, prod);
        else pass_cnt++;
        if (follow_add) begin
            set_e(5'h00, 32'd10, 32'd20, 32'h0, 32'h0, 2'b00, 2'b00, 1'b0);
            #1;
            total_cnt++;
            if (bus.stall_E !== 1'b0) $display("FAIL b2b_stall got %0b want 0", bus.stall_E);
            else pass_cnt++;
            @(posedge clk); #1;
            total_cnt++;
            if (bus.aluResult_M !== 32'd30 || bus.noop_M !== 1'b0)
                $display("FAIL b2b_add got %0d noop=%0b want 30/0", bus.aluResult_M, bus.noop_M);
            else pass_cnt++;
        end else begin
            set_e(5'h00, 32'd0, 32'd0, 32'h0, 32'h0, 2'b00, 2'b00, 1'b1);
            @(posedge clk); #1;
            total_cnt++;
            if (bus.noop_M !== 1'b1 || bus.stall_E !== 1'b0)
                $display("FAIL mul_once got noop=%0b stall=%0b want 1/0", bus.noop_M, bus.stall_E);
            else pass_cnt++;
        end
    endtask

    task automatic test_mul();
        run_mul(32'd6, 32'd7, 32'd42, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_mul(32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, 1'b1);
    endtask

    task automatic test_branch();
        set_e(5'h08, 32'd3, 32'd3, 32'd4, 32'h100, 2'b00, 2'b01, 1'b0);
        #1;
        total_cnt++;
        if (bus.pcRedirect_E !== 1'b1 || bus.pcTarget_E !== 32'h110)
            $display("FAIL beq_taken got redir=%0b tgt=%h want 1/110", bus.pcRedirect_E, bus.pcTarget_E);
        else pass_cnt++;
        bus.src2Data_E = 32'd4;
        #1;
        total_cnt++;
        if (bus.pcRedirect_E !== 1'b0)
            $display("FAIL beq_not_taken got redir=%0b want 0", bus.pcRedirect_E);
        else pass_cnt++;
        set_e(5'h00, 32'h200, 32'd0, 32'd1, 32'h44, 2'b00, 2'b10, 1'b0);
        #1;
        total_cnt++;
        if (bus.pcRedirect_E !== 1'b1 || bus.pcTarget_E !== 32'h204)
            $display("FAIL jal_target got redir=%0b tgt=%h want 1/204", bus.pcRedirect_E, bus.pcTarget_E);
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if (bus.aluResult_M !== 32'h44) $display("FAIL jal_link got %h want 44", bus.aluResult_M);
        else pass_cnt++;
        set_e(5'h00, 32'h200, 32'd0, 32'd1, 32'h44, 2'b00, 2'b10, 1'b1);
        #1;
        total_cnt++;
        if (bus.pcRedirect_E !== 1'b0) $display("FAIL noop_redirect got %0b want 0", bus.pcRedirect_E);
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if (bus.noop_M !== 1'b1 || bus.regWrtEn_M !== 1'b0)
            $display("FAIL noop_bubble got noop=%0b regWrt=%0b want 1/0", bus.noop_M, bus.regWrtEn_M);
        else pass_cnt++;
        set_e(5'h18, 32'd3, 32'd3, 32'd4, 32'h100, 2'b00, 2'b10, 1'b0);
        #1;
        total_cnt++;
        if (bus.pcRedirect_E !== 1'b0 || bus.stall_E !== 1'b1)
            $display("FAIL mul_jal got redir=%0b stall=%0b want 0/1", bus.pcRedirect_E, bus.stall_E);
        else pass_cnt++;
        #2 reset = 1'b0;
        #2 reset = 1'b1;
        bus.noop_E = 1'b1;
    endtask

    task automatic test_reset_mid_mul();
        @(posedge clk); #1;
        set_e(5'h18, 32'd6, 32'd7, 32'h0, 32'h0, 2'b00, 2'b00, 1'b0);
        for (int i = 0; i < 11; i++) begin
            @(posedge clk); #1;
        end
        reset = 1'b0;
        #1;
        total_cnt++;
        if (bus.stall_E !== 1'b0 || bus.noop_M !== 1'b1)
            $display("FAIL reset_mid_mul got stall=%0b noop=%0b want 0/1", bus.stall_E, bus.noop_M);
        else pass_cnt++;
        set_e(5'h00, 32'd1, 32'd1, 32'h0, 32'h0, 2'b00, 2'b00, 1'b0);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        total_cnt++;
        if (bus.aluResult_M !== 32'd2 || bus.stall_E !== 1'b0 || bus.noop_M !== 1'b0)
            $display("FAIL after_reset_add got %0d stall=%0b noop=%0b want 2/0/0",
                     bus.aluResult_M, bus.stall_E, bus.noop_M);
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if (bus.aluResult_M !== 32'd2 || bus.stall_E !== 1'b0)
            $display("FAIL no_resume got %0d stall=%0b want 2/0", bus.aluResult_M, bus.stall_E);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        test_reset();
        test_add();
        test_alu_ops();
        test_mul();
        test_back_to_back();
        test_branch();
        test_reset_mid_mul();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
